// File: rtl/motor_step_table_master.sv
// Stepper table player: an Avalon-MM read initiator that fetches coil-pattern
// words from a fixed-latency on-chip RAM and holds each pattern on the motor
// phase outputs for a programmable number of clocks.
module motor_step_table_master #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int DWELL_W      = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_words,
    input  logic [DWELL_W-1:0] dwell_cycles,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic              avm_clken,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [3:0]        phase_out,
    output logic              step_strobe,
    output logic              busy,
    output logic              done,
    output logic [15:0]       steps_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DWELL   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Extra wait cycles between the FETCH cycle and the CAPTURE cycle.
    localparam logic       HAS_WAIT  = (READ_LATENCY > 1) ? 1'b1 : 1'b0;
    localparam logic [1:0] WAIT_LOAD = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    state_t              state_r;
    state_t              next_s;
    logic [ADDR_W-1:0]   base_r;
    logic [15:0]         num_r;
    logic [15:0]         index_r;
    logic [1:0]          wait_cnt_r;
    logic [DWELL_W-1:0]  dwell_cnt_r;
    logic                end_r;
    logic                start_accept_s;
    logic                capture_s;
    logic [ADDR_W-1:0]   fetch_addr_s;
    logic [DWELL_W-1:0]  dwell_load_s;

    // The bus side never writes and always enables every byte lane.
    assign avm_write      = 1'b0;
    assign avm_byteenable = 4'hF;
    assign avm_clken      = 1'b1;

    // The word counter doubles as the played-steps count.
    assign steps_done = index_r;

    // Next-state decode; abort overrides every transition outside IDLE.
    always_comb begin
        next_s         = state_r;
        start_accept_s = 1'b0;
        capture_s      = 1'b0;
        fetch_addr_s   = base_r + ADDR_W'(index_r);
        if ((state_r != ST_IDLE) && abort) begin
            next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        start_accept_s = 1'b1;
                        fetch_addr_s   = base_addr;
                        if (num_words == 16'd0) begin
                            next_s = ST_DONE;
                        end else begin
                            next_s = ST_FETCH;
                        end
                    end else begin
                        next_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (HAS_WAIT) begin
                        next_s = ST_WAIT;
                    end else begin
                        next_s = ST_CAPTURE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == 2'd0) begin
                        next_s = ST_CAPTURE;
                    end else begin
                        next_s = ST_WAIT;
                    end
                end
                ST_CAPTURE: begin
                    capture_s = 1'b1;
                    next_s    = ST_DWELL;
                end
                ST_DWELL: begin
                    if (dwell_cnt_r == {DWELL_W{1'b0}}) begin
                        if (end_r || (index_r == num_r)) begin
                            next_s = ST_DONE;
                        end else begin
                            next_s = ST_FETCH;
                        end
                    end else begin
                        next_s = ST_DWELL;
                    end
                end
                ST_DONE: begin
                    next_s = ST_IDLE;
                end
                default: begin
                    next_s = ST_IDLE;
                end
            endcase
        end
    end

    // A zero dwell is held for one clock like a dwell of one.
    always_comb begin
        if (dwell_cycles == {DWELL_W{1'b0}}) begin
            dwell_load_s = {DWELL_W{1'b0}};
        end else begin
            dwell_load_s = dwell_cycles - DWELL_W'(1);
        end
    end

    // State register and the bus strobe / status outputs derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            avm_chipselect <= 1'b0;
            avm_address    <= {ADDR_W{1'b0}};
            busy           <= 1'b0;
            done           <= 1'b0;
            step_strobe    <= 1'b0;
        end else begin
            state_r        <= next_s;
            avm_chipselect <= (next_s == ST_FETCH);
            busy           <= (next_s == ST_FETCH) || (next_s == ST_WAIT) ||
                              (next_s == ST_CAPTURE) || (next_s == ST_DWELL);
            done           <= (next_s == ST_DONE);
            step_strobe    <= capture_s;
            if (next_s == ST_FETCH) begin
                avm_address <= fetch_addr_s;
            end else begin
                avm_address <= avm_address;
            end
        end
    end

    // Run parameters captured at start so later input changes do not disturb a run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r <= {ADDR_W{1'b0}};
            num_r  <= 16'd0;
        end else if (start_accept_s) begin
            base_r <= base_addr;
            num_r  <= num_words;
        end else begin
            base_r <= base_r;
            num_r  <= num_r;
        end
    end

    // Pattern capture, word index and end-marker bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_out <= 4'd0;
            index_r   <= 16'd0;
            end_r     <= 1'b0;
        end else if (start_accept_s) begin
            phase_out <= phase_out;
            index_r   <= 16'd0;
            end_r     <= 1'b0;
        end else if (capture_s) begin
            phase_out <= avm_readdata[3:0];
            index_r   <= index_r + 16'd1;
            end_r     <= avm_readdata[DATA_W-1];
        end else begin
            phase_out <= phase_out;
            index_r   <= index_r;
            end_r     <= end_r;
        end
    end

    // Read-latency wait counter and per-word dwell counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r  <= 2'd0;
            dwell_cnt_r <= {DWELL_W{1'b0}};
        end else begin
            if (state_r == ST_FETCH) begin
                wait_cnt_r <= WAIT_LOAD;
            end else if ((state_r == ST_WAIT) && (wait_cnt_r != 2'd0)) begin
                wait_cnt_r <= wait_cnt_r - 2'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (capture_s) begin
                dwell_cnt_r <= dwell_load_s;
            end else if ((state_r == ST_DWELL) && (dwell_cnt_r != {DWELL_W{1'b0}})) begin
                dwell_cnt_r <= dwell_cnt_r - DWELL_W'(1);
            end else begin
                dwell_cnt_r <= dwell_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_motor_step_table_master.sv
// Directed bench for motor_step_table_master with a one-cycle-latency RAM model.
module tb_motor_step_table_master;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [14:0] base_addr;
    logic [15:0] num_words;
    logic [23:0] dwell_cycles;
    logic [14:0] avm_address;
    logic        avm_chipselect;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic        avm_clken;
    logic [31:0] avm_readdata;
    logic [3:0]  phase_out;
    logic        step_strobe;
    logic        busy;
    logic        done;
    logic [15:0] steps_done;

    motor_step_table_master dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .num_words(num_words), .dwell_cycles(dwell_cycles),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_byteenable(avm_byteenable), .avm_clken(avm_clken),
        .avm_readdata(avm_readdata), .phase_out(phase_out), .step_strobe(step_strobe),
        .busy(busy), .done(done), .steps_done(steps_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: address captured with chipselect, data valid one cycle later.
    logic [31:0] mem [0:32767];
    logic [31:0] rdata;
    always @(posedge clk) begin
        if (avm_chipselect) rdata <= mem[avm_address];
    end
    assign avm_readdata = rdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event logs sampled on the falling edge.
    int   strobe_ph[$];
    int   strobe_cyc[$];
    int   cs_addr[$];
    int   cs_run = 0;
    int   cs_max_run = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    always @(negedge clk) begin
        if (step_strobe) begin
            strobe_ph.push_back(int'(phase_out));
            strobe_cyc.push_back(cyc);
        end
        if (avm_chipselect) begin
            cs_addr.push_back(int'(avm_address));
            cs_run = cs_run + 1;
            if (cs_run > cs_max_run) cs_max_run = cs_run;
        end else begin
            cs_run = 0;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int start_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_logs();
        strobe_ph.delete();
        strobe_cyc.delete();
        cs_addr.delete();
        cs_max_run = 0;
        done_cnt   = 0;
    endtask

    task automatic kick(input int b, input int n, input int d);
        @(negedge clk);
        base_addr    = 15'(b);
        num_words    = 16'(n);
        dwell_cycles = 24'(d);
        start        = 1'b1;
        start_cyc    = cyc;
        @(negedge clk);
        start        = 1'b0;
        base_addr    = 15'h1234;
        num_words    = 16'd7;
    endtask

    task automatic wait_done(input string tag);
        int  i;
        bit  seen;
        seen = 1'b0;
        for (i = 0; i < 2000 && !seen; i++) begin
            if (done_cnt != 0) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 32'd0;
        mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd4; mem[3] = 32'd8;
        mem[5] = 32'h8000_0003; mem[6] = 32'd5;
        mem[32766] = 32'd9; mem[32767] = 32'd6;
        mem[10] = 32'd1; mem[11] = 32'd3; mem[12] = 32'd6; mem[13] = 32'd12;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = 15'd0; num_words = 16'd0; dwell_cycles = 24'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_phase", 32'(phase_out), 32'd0);
        check("rst_cs", 32'(avm_chipselect), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_be", 32'(avm_byteenable), 32'hF);
        check("rst_clken", 32'(avm_clken), 32'd1);
        check("rst_write", 32'(avm_write), 32'd0);
        check("rst_steps", 32'(steps_done), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: four-word table, dwell 3 -> period 1+1+3 = 5
        clear_logs();
        kick(0, 4, 3);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1");
        check("t1_nstrobe", 32'(strobe_ph.size()), 32'd4);
        if (strobe_ph.size() == 4) begin
            check("t1_ph0", 32'(strobe_ph[0]), 32'd1);
            check("t1_ph1", 32'(strobe_ph[1]), 32'd2);
            check("t1_ph2", 32'(strobe_ph[2]), 32'd4);
            check("t1_ph3", 32'(strobe_ph[3]), 32'd8);
            check("t1_first_lat", 32'(strobe_cyc[0] - start_cyc), 32'd3);
            for (int k = 1; k < 4; k++)
                check("t1_spacing", 32'(strobe_cyc[k] - strobe_cyc[k-1]), 32'd5);
        end
        check("t1_steps", 32'(steps_done), 32'd4);
        check("t1_ndone", 32'(done_cnt), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_phase_hold", 32'(phase_out), 32'd8);

        // 2: end marker on the first word stops the run
        clear_logs();
        kick(5, 10, 2);
        wait_done("t2");
        check("t2_nstrobe", 32'(strobe_ph.size()), 32'd1);
        check("t2_phase", 32'(phase_out), 32'd3);
        check("t2_steps", 32'(steps_done), 32'd1);
        check("t2_ncs", 32'(cs_addr.size()), 32'd1);

        // 3: address wrap, zero dwell held as one clock -> period 3
        clear_logs();
        kick(32766, 4, 0);
        wait_done("t3");
        check("t3_ncs", 32'(cs_addr.size()), 32'd4);
        if (cs_addr.size() == 4) begin
            check("t3_a0", 32'(cs_addr[0]), 32'd32766);
            check("t3_a1", 32'(cs_addr[1]), 32'd32767);
            check("t3_a2", 32'(cs_addr[2]), 32'd0);
            check("t3_a3", 32'(cs_addr[3]), 32'd1);
        end
        check("t3_cs_pulse", 32'(cs_max_run), 32'd1);
        if (strobe_cyc.size() == 4)
            check("t3_spacing", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd3);
        check("t3_phase", 32'(phase_out), 32'd2);

        // 4: zero-length table completes without bus access
        clear_logs();
        kick(3, 0, 3);
        wait_done("t4");
        check("t4_done_lat", 32'(done_cyc - start_cyc), 32'd1);
        check("t4_ncs", 32'(cs_addr.size()), 32'd0);
        check("t4_phase", 32'(phase_out), 32'd2);
        check("t4_steps", 32'(steps_done), 32'd0);

        // 5: abort during the second word's dwell
        clear_logs();
        kick(10, 4, 8);
        for (int i = 0; i < 200 && strobe_ph.size() < 2; i++) @(negedge clk);
        check("t5_reached_w2", 32'(strobe_ph.size()), 32'd2);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        check("t5_ndone", 32'(done_cnt), 32'd0);
        check("t5_nstrobe", 32'(strobe_ph.size()), 32'd2);
        check("t5_phase", 32'(phase_out), 32'd3);
        check("t5_cs", 32'(avm_chipselect), 32'd0);

        // 6: reset in the FETCH cycle, then a clean rerun
        clear_logs();
        kick(0, 4, 1);
        check("t6_cs_fetch", 32'(avm_chipselect), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_phase", 32'(phase_out), 32'd0);
        check("t6_rst_cs", 32'(avm_chipselect), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_addr", 32'(avm_address), 32'd0);
        check("t6_rst_be", 32'(avm_byteenable), 32'hF);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_logs();
        kick(0, 4, 1);
        wait_done("t6");
        if (cs_addr.size() > 0) check("t6_first_addr", 32'(cs_addr[0]), 32'd0);
        check("t6_nstrobe", 32'(strobe_ph.size()), 32'd4);
        check("t6_steps", 32'(steps_done), 32'd4);
        check("t6_phase", 32'(phase_out), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
